// File: rtl/imm_extend_pipe.sv
// Registered immediate extender for the decode stage: zero/sign/shifted/upper extension
// behind a valid/ready handshake with a two-entry (main + skid) buffer.
module imm_extend_pipe #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    if (OUT_W <= IN_W || OUT_W < IN_W + SHIFT || IN_W < 2) begin : g_bad_params
        $error("imm_extend_pipe: illegal IN_W/OUT_W/SHIFT combination");
    end

    localparam int EXT_W = OUT_W - IN_W;

    // Handshake: a transfer happens on a rising edge when valid && ready are both high.
    // in_ready is a register (== !skid_valid), so it never depends on out_ready.
    logic             main_valid;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic [1:0]       skid_mode;
    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] sext_data;
    logic             accept;
    logic             pop;

    assign sext_data = {{EXT_W{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext_data = '0;
        case (in_mode)
            2'd0:    ext_data = {{EXT_W{1'b0}}, in_imm};
            2'd1:    ext_data = sext_data;
            2'd2:    ext_data = sext_data << SHIFT;
            default: ext_data = {in_imm, {EXT_W{1'b0}}};
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign pop       = main_valid && out_ready;
    assign out_valid = main_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            out_data   <= '0;
            out_mode   <= 2'd0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_mode  <= 2'd0;
            in_ready   <= 1'b1;
        end else if (!main_valid || pop) begin
            // Main is free this cycle: refill from skid first to keep FIFO order.
            if (skid_valid) begin
                main_valid <= 1'b1;
                out_data   <= skid_data;
                out_mode   <= skid_mode;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (accept) begin
                main_valid <= 1'b1;
                out_data   <= ext_data;
                out_mode   <= in_mode;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= ext_data;
            skid_mode  <= in_mode;
            in_ready   <= 1'b0;
        end
    end

endmodule
